// File: rtl/instruction_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// instruction_prefetch_queue_if
// Bundles the code-memory fetch bus and the decoder-facing head window of the
// instruction prefetch queue.
//   master : the prefetch queue (drives fetch_req/fetch_addr and head_*)
//   slave  : code memory + decoder side (drives fetch_data, consume_len,
//            branch_valid, branch_target)
// Parameters DEPTH / ADDR_WIDTH must match the attached queue.
// ---------------------------------------------------------------------------
interface instruction_prefetch_queue_if #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [7:0]            fetch_data;
    logic [7:0]            head_byte0;
    logic [7:0]            head_byte1;
    logic [7:0]            head_byte2;
    logic [CNT_W-1:0]      head_count;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [1:0]            consume_len;
    logic                  branch_valid;
    logic [ADDR_WIDTH-1:0] branch_target;

    modport master (
        output fetch_req, fetch_addr,
        output head_byte0, head_byte1, head_byte2, head_count, head_pc,
        input  fetch_data, consume_len, branch_valid, branch_target
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  head_byte0, head_byte1, head_byte2, head_count, head_pc,
        output fetch_data, consume_len, branch_valid, branch_target
    );
endinterface

// File: rtl/instruction_prefetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_prefetch_queue
// Fetch stage ahead of the instruction decoder. Issues sequential byte reads
// to a 1-cycle-latency code memory, buffers returned bytes in a circular FIFO
// and presents the oldest three bytes plus their PC. The decoder retires 0-3
// bytes per cycle; a taken branch flushes the queue and redirects fetch.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   pq           instruction_prefetch_queue_if.master (fetch bus + head window)
//   protocol_err sticky illegal-consume flag (only with
//                PREFETCH_PROTOCOL_CHECK_EN defined)
//
// Optional feature macro: PREFETCH_PROTOCOL_CHECK_EN
// ---------------------------------------------------------------------------
module instruction_prefetch_queue #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic clk,
    input  logic reset_n,
    instruction_prefetch_queue_if.master pq
`ifdef PREFETCH_PROTOCOL_CHECK_EN
    ,
    output logic protocol_err
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage is not reset: head_count gates every read of it.
    logic [7:0]            fifo_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic                  inflight_q, inflight_d;

    logic [CNT_W:0]        occupancy;
    logic                  fetch_req;
    logic                  push;
    logic                  consume_ok;
    logic [1:0]            pop_len;

    // Occupancy counts reads already in flight so the FIFO can never overflow,
    // even though a same-cycle consume is not credited.
    assign occupancy  = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    assign fetch_req  = reset_n && !pq.branch_valid && (occupancy < (CNT_W+1)'(DEPTH));
    assign push       = inflight_q && !pq.branch_valid;
    assign consume_ok = !pq.branch_valid && (CNT_W'(pq.consume_len) <= count_q);
    assign pop_len    = consume_ok ? pq.consume_len : 2'd0;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_pc_d    = head_pc_q;
        fetch_addr_d = fetch_addr_q;
        inflight_d   = fetch_req;
        if (pq.branch_valid) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            head_pc_d    = pq.branch_target;
            fetch_addr_d = pq.branch_target;
            inflight_d   = 1'b0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rd_ptr_d  = rd_ptr_q + PTR_W'(pop_len);
            count_d   = count_q + CNT_W'(push) - CNT_W'(pop_len);
            head_pc_d = head_pc_q + ADDR_WIDTH'(pop_len);
            if (fetch_req)
                fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_pc_q    <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            inflight_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            fetch_addr_q <= fetch_addr_d;
            inflight_q   <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= pq.fetch_data;
    end

    // Empty slots read as 0x00, a harmless single-byte opcode downstream.
    assign pq.head_byte0 = (count_q > CNT_W'(0)) ? fifo_q[rd_ptr_q]               : 8'h00;
    assign pq.head_byte1 = (count_q > CNT_W'(1)) ? fifo_q[rd_ptr_q + PTR_W'(1)]   : 8'h00;
    assign pq.head_byte2 = (count_q > CNT_W'(2)) ? fifo_q[rd_ptr_q + PTR_W'(2)]   : 8'h00;
    assign pq.head_count = count_q;
    assign pq.head_pc    = head_pc_q;
    assign pq.fetch_req  = fetch_req;
    assign pq.fetch_addr = fetch_addr_q;

`ifdef PREFETCH_PROTOCOL_CHECK_EN
    logic illegal_consume;
    logic protocol_err_q;

    assign illegal_consume = !pq.branch_valid && (CNT_W'(pq.consume_len) > count_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            protocol_err_q <= 1'b0;
        else if (illegal_consume)
            protocol_err_q <= 1'b1;
    end

    assign protocol_err = protocol_err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && illegal_consume)
            $error("illegal consume: head_pc=%h consume_len=%0d", head_pc_q, pq.consume_len);
    end
`endif
`endif

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instruction_prefetch_queue
// Scoreboard bench: every byte the queue should hold is pushed into a queue
// when its fetch is issued and popped when the decoder side retires it; the
// head window, count, PC and fetch bus are compared each cycle on the falling
// edge, plus fixed expectations at key scenario points.
// ---------------------------------------------------------------------------
module tb_instruction_prefetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    instruction_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) pq_if ();

`ifdef PREFETCH_PROTOCOL_CHECK_EN
    logic protocol_err;
`endif

    instruction_prefetch_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pq      (pq_if.master)
`ifdef PREFETCH_PROTOCOL_CHECK_EN
        ,
        .protocol_err (protocol_err)
`endif
    );

    always #5 clk = ~clk;

    // Code memory: returns addr[7:0] one cycle after a request, junk otherwise.
    always @(posedge clk)
        pq_if.fetch_data <= pq_if.fetch_req ? pq_if.fetch_addr[7:0] : 8'hEE;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]    m_q [$];
    logic [AW-1:0] m_pc, m_addr, m_infl_addr;
    logic          m_infl, m_req;

    int            cls     [3] = '{3, 2, 1};
    logic [AW-1:0] mix_pc  [3] = '{16'd3, 16'd5, 16'd6};
    logic [AW-1:0] wr_addr [3] = '{16'hFFFF, 16'h0000, 16'h0001};
    logic [AW-1:0] wr_pc   [4] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    int            guard;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input logic [AW-1:0] pc);
        m_q.delete();
        m_pc   = pc;
        m_addr = pc;
        m_infl = 1'b0;
        m_req  = 1'b0;
    endtask

    function automatic logic [7:0] m_byte(input int k);
        return (k < m_q.size()) ? m_q[k] : 8'h00;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".req"},  pq_if.fetch_req,  m_req);
        chk({tag, ".addr"}, pq_if.fetch_addr, m_addr);
        chk({tag, ".cnt"},  pq_if.head_count, m_q.size());
        chk({tag, ".pc"},   pq_if.head_pc,    m_pc);
        chk({tag, ".b0"},   pq_if.head_byte0, m_byte(0));
        chk({tag, ".b1"},   pq_if.head_byte1, m_byte(1));
        chk({tag, ".b2"},   pq_if.head_byte2, m_byte(2));
    endtask

    // Called just after a rising edge; returns 1 time unit after the next one.
    task automatic step(input logic [1:0] cl, input logic br, input logic [AW-1:0] tgt);
        int old_size;
        pq_if.consume_len   = cl;
        pq_if.branch_valid  = br;
        pq_if.branch_target = tgt;
        @(negedge clk);
        m_req = !br && ((m_q.size() + int'(m_infl)) < DEPTH);
        check_outputs("cyc");
        @(posedge clk);
        if (br) begin
            model_reset(tgt);
        end else begin
            old_size = m_q.size();
            if (m_infl)
                m_q.push_back(m_infl_addr[7:0]);
            if (int'(cl) <= old_size) begin
                repeat (int'(cl)) void'(m_q.pop_front());
                m_pc = m_pc + AW'(cl);
            end
            if (m_req) begin
                m_infl_addr = m_addr;
                m_addr      = m_addr + AW'(1);
            end
            m_infl = m_req;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pq_if.consume_len   = 2'd0;
        pq_if.branch_valid  = 1'b0;
        pq_if.branch_target = '0;
        model_reset(16'h0000);

        // Reset state
        #12;
        chk("rst.req",  pq_if.fetch_req,  0);
        chk("rst.cnt",  pq_if.head_count, 0);
        chk("rst.pc",   pq_if.head_pc,    0);
        chk("rst.addr", pq_if.fetch_addr, 0);
        chk("rst.b0",   pq_if.head_byte0, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Cold start: fill to DEPTH with no consumption
        repeat (6) step(2'd0, 1'b0, '0);
        chk("cold.cnt",  pq_if.head_count, 4);
        chk("cold.b0",   pq_if.head_byte0, 8'h00);
        chk("cold.b1",   pq_if.head_byte1, 8'h01);
        chk("cold.b2",   pq_if.head_byte2, 8'h02);
        chk("cold.pc",   pq_if.head_pc,    0);
        chk("cold.req",  pq_if.fetch_req,  0);
        chk("cold.addr", pq_if.fetch_addr, 4);

        // Mixed consume 3,2,1
        for (int i = 0; i < 3; i++) begin
            guard = 0;
            while (m_q.size() < cls[i] && guard < 10) begin
                step(2'd0, 1'b0, '0);
                guard++;
            end
            chk("mix.wait", guard < 10, 1);
            step(2'(cls[i]), 1'b0, '0);
            chk("mix.pc",   pq_if.head_pc, mix_pc[i]);
            chk("mix.cnt4", pq_if.head_count <= 4, 1);
        end

        // Steady streaming at one byte per cycle
        for (int i = 0; i < 50; i++) begin
            step((m_q.size() >= 1) ? 2'd1 : 2'd0, 1'b0, '0);
            if (m_q.size() > 0)
                chk("stream.b0", pq_if.head_byte0, m_pc[7:0]);
        end
        chk("stream.pc", pq_if.head_pc, 16'd56);

        // Branch in a cycle carrying return data and consume_len = 2
        guard = 0;
        while (!(m_infl && m_q.size() >= 2) && guard < 10) begin
            step(2'd0, 1'b0, '0);
            guard++;
        end
        chk("br.setup", guard < 10, 1);
        step(2'd2, 1'b1, 16'h1234);
        chk("br.cnt",  pq_if.head_count, 0);
        chk("br.pc",   pq_if.head_pc,    16'h1234);
        chk("br.addr", pq_if.fetch_addr, 16'h1234);
        step(2'd0, 1'b0, '0);
        step(2'd0, 1'b0, '0);
        chk("br.b0",   pq_if.head_byte0, 8'h34);
        chk("br.cnt1", pq_if.head_count, 1);

        // Address wrap-around
        step(2'd0, 1'b1, 16'hFFFE);
        chk("wrap.addr0", pq_if.fetch_addr, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step(2'd0, 1'b0, '0);
            chk("wrap.addr", pq_if.fetch_addr, wr_addr[i]);
        end
        step(2'd0, 1'b0, '0);
        chk("wrap.pc0", pq_if.head_pc, 16'hFFFE);
        for (int i = 0; i < 4; i++) begin
            step(2'd1, 1'b0, '0);
            chk("wrap.pc", pq_if.head_pc, wr_pc[i]);
        end

        // Illegal consume with one byte queued
        step(2'd0, 1'b1, 16'h0100);
        step(2'd0, 1'b0, '0);
        step(2'd0, 1'b0, '0);
        chk("ill.pre", pq_if.head_count, 1);
        step(2'd3, 1'b0, '0);
        chk("ill.pc",  pq_if.head_pc,    16'h0100);
        chk("ill.cnt", pq_if.head_count, 2);
`ifdef PREFETCH_PROTOCOL_CHECK_EN
        chk("ill.err", protocol_err, 1);
`endif
        step(2'd0, 1'b0, '0);
        step(2'd0, 1'b0, '0);
`ifdef PREFETCH_PROTOCOL_CHECK_EN
        chk("ill.sticky", protocol_err, 1);
`endif

        // Mid-operation asynchronous reset
        pq_if.consume_len  = 2'd0;
        pq_if.branch_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst.cnt",  pq_if.head_count, 0);
        chk("mrst.pc",   pq_if.head_pc,    0);
        chk("mrst.addr", pq_if.fetch_addr, 0);
        chk("mrst.req",  pq_if.fetch_req,  0);
        chk("mrst.b0",   pq_if.head_byte0, 0);
`ifdef PREFETCH_PROTOCOL_CHECK_EN
        chk("mrst.err",  protocol_err, 0);
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset(16'h0000);
        repeat (6) step(2'd0, 1'b0, '0);
        chk("rfill.cnt", pq_if.head_count, 4);
        chk("rfill.b2",  pq_if.head_byte2, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
